// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder: opcodes, flag bundle and
// the parameter legality check used at elaboration.
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic cout;
        logic zero;
        logic neg;
        logic ovf;
    } flags_t;

    function automatic bit slicing_ok(input int unsigned width, input int unsigned stages);
        return (stages >= 1) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational S-bit slice of the carry-chained adder.
module adder_slice #(
    parameter int unsigned S = 16
) (
    input  logic [S-1:0] a,
    input  logic [S-1:0] b,
    input  logic         cin,
    output logic [S-1:0] sum,
    output logic         cout,
    output logic         zero
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{S{1'b0}}, cin};
    assign zero        = (sum == '0);

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract split into STAGES carry-chained slices, one per
// pipeline stage, with valid/ready flow control and result flags.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub,
    input  logic             in_cin,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_cout,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned S = (STAGES == 0) ? WIDTH : WIDTH / STAGES;
    localparam int unsigned L = (STAGES == 0) ? 0 : STAGES - 1;

    if (!slicing_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("pipelined_adder: STAGES must be >= 1 and divide WIDTH");
    end

    logic [WIDTH-1:0]  b_eff;
    logic              c0;
    logic [WIDTH-1:0]  sl_a, sl_b, sl_sum;
    logic [STAGES-1:0] sl_cin, sl_cout, sl_zero;
    logic [STAGES:0]   adv;

    // Per-stage registers; rem_*_q keep the not-yet-consumed operand slices
    // shifted down so the next slice always sits at [S-1:0].
    logic             valid_q [STAGES];
    logic [WIDTH-1:0] y_q     [STAGES];
    logic [WIDTH-1:0] rem_a_q [STAGES];
    logic [WIDTH-1:0] rem_b_q [STAGES];
    logic             carry_q [STAGES];
    logic             zero_q  [STAGES];
    logic             a_msb_q [STAGES];
    logic             b_msb_q [STAGES];
    logic [TAG_W-1:0] tag_q   [STAGES];

    always_comb begin
        b_eff  = (in_sub == OP_SUB) ? ~in_b : in_b;
        c0     = in_sub ^ in_cin;
        sl_a   = '0;
        sl_b   = '0;
        sl_cin = '0;
        sl_a[S-1:0] = in_a[S-1:0];
        sl_b[S-1:0] = b_eff[S-1:0];
        sl_cin[0]   = c0;
        for (int unsigned k = 1; k < STAGES; k++) begin
            sl_a[k*S +: S] = rem_a_q[k-1][S-1:0];
            sl_b[k*S +: S] = rem_b_q[k-1][S-1:0];
            sl_cin[k]      = carry_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        adder_slice #(.S(S)) u_slice (
            .a    (sl_a[k*S +: S]),
            .b    (sl_b[k*S +: S]),
            .cin  (sl_cin[k]),
            .sum  (sl_sum[k*S +: S]),
            .cout (sl_cout[k]),
            .zero (sl_zero[k])
        );
    end

    // A stage may load when it is empty or its contents move on this cycle.
    always_comb begin
        adv         = '0;
        adv[STAGES] = out_ready;
        for (int unsigned k = STAGES; k > 0; k--) begin
            adv[k-1] = !valid_q[k-1] || adv[k];
        end
    end

    assign in_ready = adv[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                y_q[k]     <= '0;
                rem_a_q[k] <= '0;
                rem_b_q[k] <= '0;
                carry_q[k] <= 1'b0;
                zero_q[k]  <= 1'b0;
                a_msb_q[k] <= 1'b0;
                b_msb_q[k] <= 1'b0;
                tag_q[k]   <= '0;
            end
        end else begin
            if (adv[0]) begin
                valid_q[0] <= in_valid;
                if (in_valid) begin
                    y_q[0]     <= WIDTH'(sl_sum[S-1:0]);
                    rem_a_q[0] <= in_a >> S;
                    rem_b_q[0] <= b_eff >> S;
                    carry_q[0] <= sl_cout[0];
                    zero_q[0]  <= sl_zero[0];
                    a_msb_q[0] <= in_a[WIDTH-1];
                    b_msb_q[0] <= b_eff[WIDTH-1];
                    tag_q[0]   <= in_tag;
                end
            end
            for (int unsigned k = 1; k < STAGES; k++) begin
                if (adv[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    if (valid_q[k-1]) begin
                        y_q[k]     <= y_q[k-1] | (WIDTH'(sl_sum[k*S +: S]) << (k*S));
                        rem_a_q[k] <= rem_a_q[k-1] >> S;
                        rem_b_q[k] <= rem_b_q[k-1] >> S;
                        carry_q[k] <= sl_cout[k];
                        zero_q[k]  <= zero_q[k-1] & sl_zero[k];
                        a_msb_q[k] <= a_msb_q[k-1];
                        b_msb_q[k] <= b_msb_q[k-1];
                        tag_q[k]   <= tag_q[k-1];
                    end
                end
            end
        end
    end

    flags_t flags;

    assign flags = '{
        cout: carry_q[L],
        zero: zero_q[L],
        neg:  y_q[L][WIDTH-1],
        ovf:  (a_msb_q[L] == b_msb_q[L]) && (y_q[L][WIDTH-1] != a_msb_q[L])
    };

    assign out_valid = valid_q[L];
    assign out_y     = y_q[L];
    assign out_cout  = flags.cout;
    assign out_zero  = flags.zero;
    assign out_neg   = flags.neg;
    assign out_ovf   = flags.ovf;
    assign out_tag   = tag_q[L];

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed cases on the default configuration and
// random streams on several (WIDTH, STAGES) configurations against a model.
module tb_pipelined_adder;

    localparam int NC = 5;
    localparam int CW [NC] = '{32, 32, 32, 64, 8};
    localparam int CS [NC] = '{2, 1, 4, 8, 8};
    localparam int TW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          iv [NC], ir [NC], isub [NC], icin [NC];
    logic [63:0]   ia [NC], ib [NC], oy [NC];
    logic [TW-1:0] itag [NC], otag [NC];
    logic          ov [NC], ordy [NC], oc [NC], oz [NC], on [NC], oo [NC];

    int checks = 0;
    int passes = 0;

    for (genvar g = 0; g < NC; g++) begin : g_dut
        logic [CW[g]-1:0] y_w;
        pipelined_adder #(.WIDTH(CW[g]), .STAGES(CS[g]), .TAG_W(TW)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .in_sub    (isub[g]),
            .in_cin    (icin[g]),
            .in_a      (ia[g][CW[g]-1:0]),
            .in_b      (ib[g][CW[g]-1:0]),
            .in_tag    (itag[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .out_y     (y_w),
            .out_cout  (oc[g]),
            .out_zero  (oz[g]),
            .out_neg   (on[g]),
            .out_ovf   (oo[g]),
            .out_tag   (otag[g])
        );
        assign oy[g] = 64'(y_w);
    end

    typedef struct {
        logic [63:0]   y;
        logic          cout, zero, neg, ovf;
        logic [TW-1:0] tag;
    } res_t;

    function automatic logic [63:0] mask_of(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    // Reference: exact integer arithmetic, then wrap and judge signed range.
    function automatic res_t model(input int w, input logic sub, input logic cin,
                                   input logic [63:0] a, input logic [63:0] b,
                                   input logic [TW-1:0] tag);
        logic [63:0] mask;
        logic [65:0] ua, ub, full;
        logic signed [65:0] sa, sb, sc, r, lim;
        res_t m;
        mask = mask_of(w);
        ua = {2'b00, a & mask};
        ub = {2'b00, b & mask};
        sa = $signed(ua);
        sb = $signed(ub);
        sc = $signed({65'd0, cin});
        if (a[w-1]) sa = sa - (66'sd1 <<< w);
        if (b[w-1]) sb = sb - (66'sd1 <<< w);
        lim = 66'sd1 <<< (w - 1);
        if (!sub) begin
            full   = ua + ub + 66'(cin);
            m.cout = full[w];
            r      = sa + sb + sc;
        end else begin
            full   = ua - ub - 66'(cin);
            m.cout = (ua >= ub + 66'(cin));
            r      = sa - sb - sc;
        end
        m.y    = full[63:0] & mask;
        m.ovf  = (r >= lim) || (r < -lim);
        m.zero = (m.y == 64'd0);
        m.neg  = m.y[w-1];
        m.tag  = tag;
        return m;
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] mask;
        mask = mask_of(w);
        case ($urandom % 8)
            0: return 64'd0;
            1: return 64'd1;
            2: return mask;
            3: return 64'd1 << (w - 1);
            4: return mask >> 1;
            default: return {$urandom, $urandom} & mask;
        endcase
    endfunction

    function automatic logic [72:0] out_vec(input int d);
        return {oy[d], oc[d], oz[d], on[d], oo[d], otag[d]};
    endfunction

    function automatic logic [72:0] exp_vec(input res_t m);
        return {m.y, m.cout, m.zero, m.neg, m.ovf, m.tag};
    endfunction

    task automatic do_single(input int d, input string name, input logic sub, input logic cin,
                             input logic [63:0] a, input logic [63:0] b, input logic [TW-1:0] tag);
        res_t m;
        int   cyc;
        bit   seen;
        m = model(CW[d], sub, cin, a, b, tag);
        seen = 0;
        @(negedge clk);
        ordy[d] = 1'b1;
        isub[d] = sub; icin[d] = cin; ia[d] = a; ib[d] = b; itag[d] = tag;
        iv[d] = 1'b1;
        #1;
        checks++;
        if (ir[d] !== 1'b1) $display("FAIL %s_ready: got %b expected 1", name, ir[d]);
        else passes++;
        for (cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            iv[d] = 1'b0;
            if (ov[d] === 1'b1) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen || cyc != CS[d]) $display("FAIL %s_latency: got %0d cycles (seen=%0d) expected %0d", name, cyc, seen, CS[d]);
        else passes++;
        checks++;
        if (out_vec(d) !== exp_vec(m)) $display("FAIL %s_result: got %h expected %h", name, out_vec(d), exp_vec(m));
        else passes++;
    endtask

    task automatic run_stream(input int d, input string name, input int n, input int stall_pct,
                              input int gap_pct, input bit seq_tags, output int cycles);
        res_t        q[$];
        res_t        m;
        int          sent, got, budget;
        bit          presenting, have_snap, exp_ready;
        logic [72:0] snap;
        sent = 0; got = 0; cycles = 0; presenting = 0; have_snap = 0; snap = '0;
        budget = n * 8 + 50;
        while (got < n && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (have_snap) begin
                checks++;
                if ({ov[d], out_vec(d)} !== {1'b1, snap})
                    $display("FAIL %s_stall_hold: got %h expected %h", name, {ov[d], out_vec(d)}, {1'b1, snap});
                else passes++;
            end
            if (!presenting && sent < n && $urandom_range(99) >= gap_pct) begin
                presenting = 1;
                isub[d] = 1'($urandom % 2);
                icin[d] = 1'($urandom % 2);
                ia[d]   = pick(CW[d]);
                ib[d]   = pick(CW[d]);
                itag[d] = seq_tags ? TW'(sent) : TW'($urandom);
            end
            iv[d]   = presenting;
            ordy[d] = ($urandom_range(99) >= stall_pct);
            #1;
            exp_ready = !(q.size() == CS[d] && !ordy[d]);
            checks++;
            if (ir[d] !== exp_ready) $display("FAIL %s_in_ready: got %b expected %b (inflight %0d)", name, ir[d], exp_ready, q.size());
            else passes++;
            have_snap = (ov[d] === 1'b1) && !ordy[d];
            snap = out_vec(d);
            if (ov[d] === 1'b1 && ordy[d]) begin
                checks++;
                if (q.size() == 0) begin
                    $display("FAIL %s_result[%0d]: got %h expected no result", name, got, out_vec(d));
                end else begin
                    m = q.pop_front();
                    if (out_vec(d) !== exp_vec(m))
                        $display("FAIL %s_result[%0d]: got %h expected %h", name, got, out_vec(d), exp_vec(m));
                    else passes++;
                end
                got++;
            end
            if (iv[d] && ir[d] === 1'b1) begin
                q.push_back(model(CW[d], isub[d], icin[d], ia[d], ib[d], itag[d]));
                sent++;
                presenting = 0;
            end
        end
        iv[d] = 1'b0;
        ordy[d] = 1'b1;
        checks++;
        if (got != n) $display("FAIL %s_complete: got %0d results expected %0d", name, got, n);
        else passes++;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ov[0] !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", ov[0]); else passes++;
        checks++;
        if (oy[0] !== 64'd0) $display("FAIL reset_out_y: got %h expected 0", oy[0]); else passes++;
        checks++;
        if ({oc[0], oz[0], on[0], oo[0]} !== 4'b0000)
            $display("FAIL reset_flags: got %b expected 0000", {oc[0], oz[0], on[0], oo[0]});
        else passes++;
        checks++;
        if (otag[0] !== '0) $display("FAIL reset_out_tag: got %h expected 0", otag[0]); else passes++;
        checks++;
        if (ir[0] !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", ir[0]); else passes++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        do_single(0, "add_wrap", 1'b0, 1'b0, 64'hFFFF_FFFF, 64'd1, 5'd3);
        do_single(0, "add_plain", 1'b0, 1'b1, 64'h1234_5678, 64'h0FED_CBA9, 5'd9);
    endtask

    task automatic test_sub();
        do_single(0, "sub_neg", 1'b1, 1'b0, 64'd5, 64'd7, 5'd4);
        do_single(0, "sub_ovf", 1'b1, 1'b0, 64'h8000_0000, 64'd1, 5'd5);
    endtask

    task automatic test_carry_boundary();
        do_single(0, "carry_slice", 1'b0, 1'b1, 64'h0000_FFFF, 64'd1, 5'd6);
        do_single(0, "carry_chain", 1'b0, 1'b1, 64'hFFFF_FFFF, 64'd0, 5'd7);
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        ordy[0] = 1'b0;
        isub[0] = 1'b0; icin[0] = 1'b0; ia[0] = 64'd10; ib[0] = 64'd20; itag[0] = 5'd1;
        iv[0] = 1'b1;
        @(negedge clk);
        ia[0] = 64'd30; itag[0] = 5'd2;
        @(negedge clk);
        iv[0] = 1'b0;
        checks++;
        if (ov[0] !== 1'b1) $display("FAIL midflight_valid: got %b expected 1", ov[0]); else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ov[0], oy[0]} !== 65'd0) $display("FAIL midflight_async_clear: got %h expected 0", {ov[0], oy[0]});
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        ordy[0] = 1'b1;
        do_single(0, "after_reset", 1'b1, 1'b1, 64'd100, 64'd40, 5'd17);
    endtask

    task automatic test_backpressure();
        int cyc;
        run_stream(0, "backpressure", 8, 50, 0, 1'b1, cyc);
    endtask

    task automatic test_back_to_back();
        int cyc;
        run_stream(0, "back_to_back", 64, 0, 0, 1'b0, cyc);
        checks++;
        if (cyc != 64 + CS[0]) $display("FAIL back_to_back_cycles: got %0d expected %0d", cyc, 64 + CS[0]);
        else passes++;
    endtask

    task automatic test_sweep();
        int c1, c2, c3, c4;
        fork
            run_stream(1, "sweep_32x1", 10000, 25, 20, 1'b0, c1);
            run_stream(2, "sweep_32x4", 10000, 25, 20, 1'b0, c2);
            run_stream(3, "sweep_64x8", 10000, 25, 20, 1'b0, c3);
            run_stream(4, "sweep_8x8",  10000, 25, 20, 1'b0, c4);
        join
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < NC; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b1; isub[d] = 1'b0; icin[d] = 1'b0;
            ia[d] = '0; ib[d] = '0; itag[d] = '0;
        end
        test_reset();
        test_add();
        test_sub();
        test_carry_boundary();
        test_reset_midflight();
        test_backpressure();
        test_back_to_back();
        test_sweep();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
